// File: rtl/freq_set.sv
// rtl/freq_set.sv - front-panel frequency setter with debounced up/down keys
//
// Purpose: debounces NKEY up-keys and NKEY down-keys (key i steps by 10^i),
//   keeps a wrapping setpoint within [F_MIN, F_MAX] and accepts a clamped host
//   load. Optional auto-repeat of held keys when FREQ_SET_REPEAT_EN is defined.
// Ports:
//   clk_sys        sole clock
//   rst            synchronous active-high reset
//   key_up[NKEY]   raw asynchronous up-keys, active-high
//   key_dn[NKEY]   raw asynchronous down-keys, active-high
//   tick           slow-time strobe for auto-repeat (ignored without the macro)
//   ld, ld_val     host load strobe and value
//   freq           current setpoint
//   upd            one-cycle pulse whenever freq is written
module freq_set #(
  parameter int NKEY    = 3,
  parameter int DW      = 10,
  parameter int DEB_LEN = 8,
  parameter int F_MIN   = 0,
  parameter int F_MAX   = 999,
  parameter int F_INIT  = 50,
  parameter int REP_DLY = 50,
  parameter int REP_PER = 10
) (
  input  logic            clk_sys,
  input  logic            rst,
  input  logic [NKEY-1:0] key_up,
  input  logic [NKEY-1:0] key_dn,
  input  logic            tick,
  input  logic            ld,
  input  logic [DW-1:0]   ld_val,
  output logic [DW-1:0]   freq,
  output logic            upd
);

  localparam int NK2 = 2 * NKEY;
  localparam logic [DW:0] FMIN_X = (DW+1)'(F_MIN);
  localparam logic [DW:0] FMAX_X = (DW+1)'(F_MAX);
  localparam logic [DW:0] RNG_X  = (DW+1)'(F_MAX - F_MIN + 1);

  function automatic logic [DW:0] pow10(input int i);
    case (i)
      0:       return (DW+1)'(1);
      1:       return (DW+1)'(10);
      2:       return (DW+1)'(100);
      default: return (DW+1)'(1000);
    endcase
  endfunction

  function automatic logic [DW:0] step_up(input logic [DW:0] f, input logic [DW:0] p);
    logic [DW:0] s;
    s = f + p;
    return (s > FMAX_X) ? s - RNG_X : s;
  endfunction

  function automatic logic [DW:0] step_dn(input logic [DW:0] f, input logic [DW:0] p);
    return (f < FMIN_X + p) ? f + RNG_X - p : f - p;
  endfunction

  // Key vector ordered by ascending priority: down keys in the low half,
  // up keys in the high half, higher index higher within each half.
  logic [NK2-1:0]              raw, s1, s2, lvl, ev, rep, ev_all;
  logic [NK2-1:0][DEB_LEN-1:0] sh;

  assign raw    = {key_up, key_dn};
  assign ev_all = ev | rep;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      sh  <= '0;
      lvl <= '0;
      ev  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int j = 0; j < NK2; j++) begin
        sh[j] <= {sh[j][DEB_LEN-2:0], s2[j]};
        ev[j] <= 1'b0;
        if (&sh[j]) begin
          lvl[j] <= 1'b1;
          ev[j]  <= ~lvl[j];
        end else if (~|sh[j]) begin
          lvl[j] <= 1'b0;
        end
      end
    end
  end

`ifdef FREQ_SET_REPEAT_EN
  localparam int SW  = $clog2(NK2 + 1);
  localparam int CMX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int CW  = $clog2(CMX + 1);

  // sel: 0 when nothing is held, else 1 + index of the highest-priority held key.
  logic [SW-1:0] sel, sel_q;
  logic [CW-1:0] cnt;
  logic          started;

  always_comb begin
    sel = '0;
    for (int j = 0; j < NK2; j++) begin
      if (lvl[j]) sel = SW'(j + 1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sel_q   <= '0;
      cnt     <= '0;
      started <= 1'b0;
      rep     <= '0;
    end else begin
      rep <= '0;
      if (sel != sel_q || sel == '0) begin
        sel_q   <= sel;
        cnt     <= '0;
        started <= 1'b0;
      end else if (tick) begin
        if ((!started && cnt == CW'(REP_DLY - 1)) || (started && cnt == CW'(REP_PER - 1))) begin
          started <= 1'b1;
          cnt     <= '0;
          for (int j = 0; j < NK2; j++) begin
            if (sel_q == SW'(j + 1)) rep[j] <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign rep         = '0;
`endif

  // One action per cycle; later assignments override earlier ones, so the
  // loop order plus the final ld check realise the priority ladder.
  logic [DW:0] freq_x, nxt;
  logic        act;
  logic        unused_msb;

  assign freq_x     = {1'b0, freq};
  assign unused_msb = nxt[DW];

  always_comb begin
    act = 1'b0;
    nxt = freq_x;
    for (int j = 0; j < NK2; j++) begin
      if (ev_all[j]) begin
        act = 1'b1;
        if (j >= NKEY) nxt = step_up(freq_x, pow10(j - NKEY));
        else           nxt = step_dn(freq_x, pow10(j));
      end
    end
    if (ld) begin
      act = 1'b1;
      if ({1'b0, ld_val} < FMIN_X)      nxt = FMIN_X;
      else if ({1'b0, ld_val} > FMAX_X) nxt = FMAX_X;
      else                              nxt = {1'b0, ld_val};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      freq <= DW'(F_INIT);
      upd  <= 1'b0;
    end else begin
      upd <= act;
      if (act) freq <= nxt[DW-1:0];
    end
  end

endmodule

// File: tb/tb_freq_set.sv
// tb/tb_freq_set.sv - scoreboard bench for freq_set (DEB_LEN=4)
module tb_freq_set;
  localparam int NKEY = 3;
  localparam int DW   = 10;

  logic            clk_sys = 1'b0;
  logic            rst     = 1'b1;
  logic [NKEY-1:0] key_up  = '0;
  logic [NKEY-1:0] key_dn  = '0;
  logic            tick    = 1'b0;
  logic            ld      = 1'b0;
  logic [DW-1:0]   ld_val  = '0;
  logic [DW-1:0]   freq;
  logic            upd;

  int checks = 0;
  int errors = 0;
  int sb[$];

  freq_set #(.DEB_LEN(4)) dut (
    .clk_sys(clk_sys), .rst(rst), .key_up(key_up), .key_dn(key_dn),
    .tick(tick), .ld(ld), .ld_val(ld_val), .freq(freq), .upd(upd)
  );

  always #5 clk_sys = ~clk_sys;

  // Every upd pulse must match the next expected setpoint in the scoreboard.
  always @(negedge clk_sys) begin
    if (upd) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL upd_unexpected: freq=%0d with no expected update", freq);
      end else begin
        int exp_f;
        exp_f = sb.pop_front();
        assert (int'(freq) === exp_f) else begin
          errors++;
          $error("FAIL sb_freq: observed %0d expected %0d", freq, exp_f);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    // reset
    step(3);
    rst = 1'b0;
    check("reset_freq", int'(freq), 50);
    check("reset_upd", int'(upd), 0);

    // clean press of key_up[1]: edge 7 after the first high sample
    sb.push_back(60);
    key_up[1] = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      step(1);
      if (e < 7) begin
        check("lat_upd_low", int'(upd), 0);
        check("lat_freq_old", int'(freq), 50);
      end else if (e == 7) begin
        check("lat_upd_hi", int'(upd), 1);
        check("lat_freq_new", int'(freq), 60);
      end else begin
        check("upd_width", int'(upd), 0);
      end
    end
    key_up[1] = 1'b0;
    step(12);
    check("release_no_action", int'(freq), 60);

    // bouncing key_up[0], then steady: one step only
    for (int i = 0; i < 10; i++) begin
      key_up[0] = ~key_up[0];
      step(2);
    end
    sb.push_back(61);
    key_up[0] = 1'b1;
    step(12);
    key_up[0] = 1'b0;
    step(12);
    check("bounce_one_step", int'(freq), 61);

    // load 995, up 100 wraps to 95
    sb.push_back(995);
    ld = 1'b1; ld_val = 10'd995;
    step(1);
    ld = 1'b0;
    check("load_995", int'(freq), 995);
    sb.push_back(95);
    key_up[2] = 1'b1;
    step(12);
    key_up[2] = 1'b0;
    step(12);
    check("wrap_up", int'(freq), 95);

    // load 5, down 10 wraps to 995
    sb.push_back(5);
    ld = 1'b1; ld_val = 10'd5;
    step(1);
    ld = 1'b0;
    sb.push_back(995);
    key_dn[1] = 1'b1;
    step(12);
    key_dn[1] = 1'b0;
    step(12);
    check("wrap_dn", int'(freq), 995);

    // load of 1023 clamps to 999 and beats a coincident key_up[2] event
    sb.push_back(999);
    key_up[2] = 1'b1;
    step(7);
    ld = 1'b1; ld_val = 10'd1023;
    step(1);
    ld = 1'b0;
    check("ld_prio_freq", int'(freq), 999);
    check("ld_prio_upd", int'(upd), 1);
    step(1);
    check("ld_prio_single", int'(upd), 0);
    key_up[2] = 1'b0;
    step(12);
    check("ld_prio_final", int'(freq), 999);

    // simultaneous key_up[0] and key_dn[2]: only +1, which wraps 999 -> 0
    sb.push_back(0);
    key_up[0] = 1'b1; key_dn[2] = 1'b1;
    step(12);
    key_up[0] = 1'b0; key_dn[2] = 1'b0;
    step(12);
    check("up_beats_dn", int'(freq), 0);

    // held key with ticks: repeats only when the feature is built in
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("reset2_freq", int'(freq), 50);
    sb.push_back(51);
`ifdef FREQ_SET_REPEAT_EN
    sb.push_back(52);
    sb.push_back(53);
    sb.push_back(54);
`endif
    key_up[0] = 1'b1;
    step(12);
    for (int t = 0; t < 75; t++) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(2);
    end
    key_up[0] = 1'b0;
    step(12);
`ifdef FREQ_SET_REPEAT_EN
    check("repeat_final", int'(freq), 54);
`else
    check("repeat_final", int'(freq), 51);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
